cache_store_merger: RTL and testbench

// - Single-line store-merge buffer between CPU store port and cache data array.
// - Collects byte-enabled stores to one cache line and merges them into a full line.
// - On drain, a fully-written line goes straight to write-back.
// - A partial line first reads the old line (hit data or refill), merges, then writes back.
// - Parametrised multi-byte successor of the one-byte-per-write merge path.

---
 rtl/cache_pkg.sv | 29 ++
 rtl/line_byte_merge.sv | 19 +
 rtl/cache_store_merger.sv | 184 ++++++++++++++++++
 tb/tb_cache_store_merger.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the store-merge buffer.
//   state_t         : controller states
//   off_width()     : byte-offset bits inside a line
//   word_off_width(): byte-offset bits inside a store word
//   cnt_width()     : width of the idle counter for a given timeout
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        RD_REQ,
        RD_WAIT,
        WRITE
    } state_t;

    function automatic int off_width(input int line_w);
        return $clog2(line_w / 8);
    endfunction

    function automatic int word_off_width(input int word_w);
        return $clog2(word_w / 8);
    endfunction

    // The counter only has to reach TIMEOUT-1.
    function automatic int cnt_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/line_byte_merge.sv
// Combinational per-byte select between two lines.
//   new_line : bytes taken where mask is set
//   old_line : bytes taken where mask is clear
//   mask     : one bit per byte
//   merged   : result
module line_byte_merge #(
    parameter int LINE_W = 64
) (
    input  logic [LINE_W-1:0]   new_line,
    input  logic [LINE_W-1:0]   old_line,
    input  logic [LINE_W/8-1:0] mask,
    output logic [LINE_W-1:0]   merged
);

    for (genvar gi = 0; gi < LINE_W / 8; gi++) begin : g_byte
        assign merged[gi*8 +: 8] = mask[gi] ? new_line[gi*8 +: 8] : old_line[gi*8 +: 8];
    end

endmodule

// File: rtl/cache_store_merger.sv
// Single-line store-merge buffer between a CPU store port and a cache data array.
// Stores to one line are collected with byte enables. On drain a fully written
// line is written back directly; a partial line first fetches the old line and
// fills the unwritten bytes from it.
//   clk, reset                     : clock, synchronous active-high reset
//   st_valid/st_ready/st_addr/
//   st_data/st_be                  : store request port
//   flush                          : force drain of the buffered line
//   rd_req_valid/ready/addr        : old-line read request
//   rd_rsp_valid/rd_rsp_data       : old-line read response (single-cycle pulse)
//   wb_valid/ready/addr/data/mask  : merged line write-back
//   busy                           : controller not idle
module cache_store_merger
    import cache_pkg::*;
#(
    parameter int LINE_W  = 64,
    parameter int WORD_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                st_valid,
    output logic                st_ready,
    input  logic [ADDR_W-1:0]   st_addr,
    input  logic [WORD_W-1:0]   st_data,
    input  logic [WORD_W/8-1:0] st_be,
    input  logic                flush,
    output logic                rd_req_valid,
    input  logic                rd_req_ready,
    output logic [ADDR_W-1:0]   rd_req_addr,
    input  logic                rd_rsp_valid,
    input  logic [LINE_W-1:0]   rd_rsp_data,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [ADDR_W-1:0]   wb_addr,
    output logic [LINE_W-1:0]   wb_data,
    output logic [LINE_W/8-1:0] wb_mask,
    output logic                busy
);

    localparam int LINE_BYTES = LINE_W / 8;
    localparam int WORD_BYTES = WORD_W / 8;
    localparam int LANES      = LINE_W / WORD_W;
    localparam int OFF_W      = off_width(LINE_W);
    localparam int WOFF_W     = word_off_width(WORD_W);
    localparam int TAG_W      = ADDR_W - OFF_W;
    localparam int CNT_W      = cnt_width(TIMEOUT);

    state_t                  state_reg, state_next;
    logic [TAG_W-1:0]        tag_reg, tag_next;
    logic [LINE_W-1:0]       buf_reg, buf_next;
    logic [LINE_BYTES-1:0]   mask_reg, mask_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;

    logic [TAG_W-1:0]        st_tag;
    logic [OFF_W-1:0]        st_lane;
    logic [LINE_W-1:0]       st_line;
    logic [LINE_BYTES-1:0]   st_mask;
    logic [LINE_W-1:0]       st_merged;
    logic [LINE_W-1:0]       rsp_merged;
    logic                    tag_match;
    logic                    drain;

    assign st_tag    = st_addr[ADDR_W-1:OFF_W];
    assign st_lane   = st_addr[OFF_W-1:0] >> WOFF_W;
    assign tag_match = (st_tag == tag_reg);

    // Store word replicated into every lane; the byte mask selects the real one.
    assign st_line = {LANES{st_data}};

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign st_mask[gi*WORD_BYTES +: WORD_BYTES] =
            (st_lane == OFF_W'(gi)) ? st_be : '0;
    end

    // Store path: new store bytes over the buffer.
    line_byte_merge #(.LINE_W(LINE_W)) u_st_merge (
        .new_line (st_line),
        .old_line (buf_reg),
        .mask     (st_mask),
        .merged   (st_merged)
    );

    // Refill path: buffered bytes over the old line.
    line_byte_merge #(.LINE_W(LINE_W)) u_rsp_merge (
        .new_line (buf_reg),
        .old_line (rd_rsp_data),
        .mask     (mask_reg),
        .merged   (rsp_merged)
    );

    always_comb begin
        state_next = state_reg;
        tag_next   = tag_reg;
        buf_next   = buf_reg;
        mask_next  = mask_reg;
        cnt_next   = cnt_reg;
        st_ready   = 1'b0;
        drain      = 1'b0;

        case (state_reg)
            IDLE: begin
                st_ready = 1'b1;
                if (st_valid && (st_be != '0)) begin
                    tag_next   = st_tag;
                    buf_next   = st_merged;
                    mask_next  = st_mask;
                    cnt_next   = '0;
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                st_ready = st_valid && tag_match && !flush;
                if (st_ready) begin
                    buf_next  = st_merged;
                    mask_next = mask_reg | st_mask;
                    cnt_next  = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
                drain = flush || (st_valid && !tag_match) ||
                        (cnt_reg == CNT_W'(TIMEOUT - 1));
                // A store accepted in the timeout cycle is included in the
                // drain, so the full-line test uses the updated mask.
                if (drain) begin
                    state_next = (&mask_next) ? WRITE : RD_REQ;
                end
            end
            RD_REQ: begin
                if (rd_req_ready) begin
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rd_rsp_valid) begin
                    buf_next   = rsp_merged;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (wb_ready) begin
                    mask_next  = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // No store may be taken while reset is asserted.
        if (reset) begin
            st_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            tag_reg   <= '0;
            buf_reg   <= '0;
            mask_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            tag_reg   <= tag_next;
            buf_reg   <= buf_next;
            mask_reg  <= mask_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Outputs are decoded from registers; reset forces the status outputs low
    // in the reset cycle itself.
    assign rd_req_valid = !reset && (state_reg == RD_REQ);
    assign wb_valid     = !reset && (state_reg == WRITE);
    assign busy         = !reset && (state_reg != IDLE);
    assign rd_req_addr  = {tag_reg, {OFF_W{1'b0}}};
    assign wb_addr      = {tag_reg, {OFF_W{1'b0}}};
    assign wb_data      = buf_reg;
    assign wb_mask      = mask_reg;

endmodule

// File: tb/tb_cache_store_merger.sv
module tb_cache_store_merger;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_be;
    logic        flush;
    logic        rd_req_valid;
    logic        rd_req_ready;
    logic [31:0] rd_req_addr;
    logic        rd_rsp_valid;
    logic [63:0] rd_rsp_data;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_addr;
    logic [63:0] wb_data;
    logic [7:0]  wb_mask;
    logic        busy;

    always #5 clk = ~clk;

    cache_store_merger #(
        .LINE_W(64), .WORD_W(32), .ADDR_W(32), .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_data(st_data), .st_be(st_be), .flush(flush),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_addr(rd_req_addr), .rd_rsp_valid(rd_rsp_valid),
        .rd_rsp_data(rd_rsp_data), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_data(wb_data), .wb_mask(wb_mask), .busy(busy)
    );

    typedef struct {
        logic [31:0] a0; logic [31:0] d0; logic [3:0] be0;
        bit          two;
        logic [31:0] a1; logic [31:0] d1; logic [3:0] be1;
        bit          exp_rd;
        logic [31:0] rd_addr;
        logic [63:0] rsp;
        logic [31:0] wb_addr;
        logic [63:0] wb_data;
        logic [7:0]  wb_mask;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  mask;
    } wb_t;

    wb_t exp_q[$];
    vec_t vecs[6];

    int checks = 0;
    int errors = 0;
    bit stall_mon = 1'b0;
    int stall_bad = 0;
    int busy_bad  = 0;

    always @(negedge clk) begin
        if (stall_mon) begin
            if (st_ready) stall_bad++;
            if (!busy)    busy_bad++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        int n = 0;
        @(negedge clk);
        st_valid = 1'b1; st_addr = a; st_data = d; st_be = be;
        #1;
        while (!st_ready && n < 100) begin
            @(negedge clk); #1; n++;
        end
        chk("st_accept", {63'd0, st_ready}, 64'd1);
        @(posedge clk); #1;
        st_valid = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic wait_rd(input logic [31:0] exp_addr, input logic [63:0] rsp);
        int n = 0;
        @(negedge clk);
        while (!rd_req_valid && n < 100) begin
            @(negedge clk); n++;
        end
        chk("rd_req_seen", {63'd0, rd_req_valid}, 64'd1);
        if (rd_req_valid) begin
            chk("rd_req_addr", {32'd0, rd_req_addr}, {32'd0, exp_addr});
            rd_req_ready = 1'b1;
            @(posedge clk); #1;
            rd_req_ready = 1'b0;
            @(negedge clk);
            rd_rsp_valid = 1'b1; rd_rsp_data = rsp;
            @(posedge clk); #1;
            rd_rsp_valid = 1'b0;
        end
    endtask

    task automatic wait_wb(input int hold, output int lat);
        int n = 0;
        int unstable = 0;
        wb_t cap, e;
        @(negedge clk);
        while (!wb_valid && n < 200) begin
            @(negedge clk); n++;
        end
        lat = n;
        chk("wb_valid_seen", {63'd0, wb_valid}, 64'd1);
        if (wb_valid) begin
            cap = '{wb_addr, wb_data, wb_mask};
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                if (!wb_valid || wb_addr !== cap.addr || wb_data !== cap.data || wb_mask !== cap.mask)
                    unstable++;
            end
            if (hold > 0) chk("wb_stable", 64'(unstable), 64'd0);
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wb_addr", {32'd0, wb_addr}, {32'd0, e.addr});
                chk("wb_data", wb_data, e.data);
                chk("wb_mask", {56'd0, wb_mask}, {56'd0, e.mask});
                $display("wb addr=%h data=%h mask=%h exp_data=%h", wb_addr, wb_data, wb_mask, e.data);
            end
            wb_ready = 1'b1;
            @(posedge clk); #1;
            wb_ready = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        vec_t v;

        //        a0        d0            be0   two a1         d1            be1   rd rd_addr     rsp                      wb_addr      wb_data                  mask
        vecs[0] = '{32'h100, 32'hAABBCCDD, 4'hF, 1, 32'h104, 32'h11223344, 4'hF, 0, 32'h0,   64'h0,                   32'h100, 64'h11223344AABBCCDD, 8'hFF};
        vecs[1] = '{32'h108, 32'h0000EE00, 4'h2, 0, 32'h0,   32'h0,        4'h0, 1, 32'h108, 64'h0123456789ABCDEF, 32'h108, 64'h0123456789ABEEEF, 8'h02};
        vecs[2] = '{32'h100, 32'h000000AA, 4'h1, 1, 32'h100, 32'h000000BB, 4'h1, 1, 32'h100, 64'h0,                   32'h100, 64'h00000000000000BB, 8'h01};
        vecs[3] = '{32'h104, 32'hCAFEBABE, 4'hC, 0, 32'h0,   32'h0,        4'h0, 1, 32'h100, 64'hFFFFFFFFFFFFFFFF, 32'h100, 64'hCAFEFFFFFFFFFFFF, 8'hC0};
        vecs[4] = '{32'h20C, 32'h12345678, 4'hF, 1, 32'h208, 32'h9ABCDEF0, 4'hF, 0, 32'h0,   64'h0,                   32'h208, 64'h123456789ABCDEF0, 8'hFF};
        vecs[5] = '{32'h1F0, 32'hDEADBEEF, 4'h9, 1, 32'h1F4, 32'h01020304, 4'h6, 1, 32'h1F0, 64'h1111111111111111, 32'h1F0, 64'h11020311DE1111EF, 8'h69};

        reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
        flush = 1'b0; rd_req_ready = 1'b0; rd_rsp_valid = 1'b0; rd_rsp_data = '0;
        wb_ready = 1'b0;

        // Reset cycle: everything low even with a store offered.
        repeat (2) @(posedge clk);
        @(negedge clk);
        st_valid = 1'b1; st_addr = 32'h100; st_be = 4'hF;
        #1;
        chk("rst_st_ready", {63'd0, st_ready}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_valids", {62'd0, rd_req_valid, wb_valid}, 64'd0);
        st_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_st_ready", {63'd0, st_ready}, 64'd1);
        chk("post_rst_mask", {56'd0, wb_mask}, 64'd0);

        // Table-driven drains.
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            exp_q.push_back('{v.wb_addr, v.wb_data, v.wb_mask});
            do_store(v.a0, v.d0, v.be0);
            if (v.two) do_store(v.a1, v.d1, v.be1);
            do_flush();
            if (v.exp_rd) wait_rd(v.rd_addr, v.rsp);
            wait_wb(0, lat);
            if (!v.exp_rd) chk("full_mask_latency", 64'(lat), 64'd0);
            $display("vec %0d done rd=%0d latency=%0d", i, v.exp_rd, lat);
        end

        // Zero byte-enable store in IDLE is consumed without effect.
        do_store(32'h500, 32'hFFFFFFFF, 4'h0);
        @(negedge clk);
        chk("zero_be_busy", {63'd0, busy}, 64'd0);
        $display("zero-be store consumed busy=%0d", busy);

        // Mismatching store stalls through the drain of the current line.
        do_store(32'h100, 32'h00000055, 4'h1);
        exp_q.push_back('{32'h100, 64'h0000000000000055, 8'h01});
        @(negedge clk);
        st_valid = 1'b1; st_addr = 32'h200; st_data = 32'h13579BDF; st_be = 4'hF;
        #1;
        chk("stall_ready", {63'd0, st_ready}, 64'd0);
        stall_mon = 1'b1;
        wait_rd(32'h100, 64'h0);
        wait_wb(0, lat);
        stall_mon = 1'b0;
        chk("stall_ready_during_drain", 64'(stall_bad), 64'd0);
        chk("stall_busy_during_drain", 64'(busy_bad), 64'd0);
        @(negedge clk); #1;
        chk("stall_accept_after_wb", {63'd0, st_ready}, 64'd1);
        @(posedge clk); #1;
        st_valid = 1'b0;
        @(negedge clk);
        chk("stall_busy_after_accept", {63'd0, busy}, 64'd1);
        exp_q.push_back('{32'h200, 64'hFFFFFFFF13579BDF, 8'h0F});
        do_flush();
        wait_rd(32'h200, 64'hFFFFFFFF00000000);
        wait_wb(0, lat);
        $display("stall sequence done");

        // Idle timeout drains automatically; write-back held for five cycles.
        do_store(32'h300, 32'h000000A5, 4'h1);
        exp_q.push_back('{32'h300, 64'hFFFFFFFFFFFFFFA5, 8'h01});
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!rd_req_valid && n < 40);
        chk("timeout_cycles", 64'(n), 64'd16);
        wait_rd(32'h300, 64'hFFFFFFFFFFFFFF00);
        wait_wb(5, lat);
        $display("timeout drain after %0d cycles", n);

        // Reset while waiting for the old line aborts without write-back.
        do_store(32'h400, 32'h00000077, 4'h1);
        do_flush();
        @(negedge clk);
        chk("abort_rd_req", {63'd0, rd_req_valid}, 64'd1);
        rd_req_ready = 1'b1;
        @(posedge clk); #1;
        rd_req_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_busy_in_reset", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        rd_rsp_valid = 1'b1; rd_rsp_data = 64'h5555555555555555;
        @(posedge clk); #1;
        rd_rsp_valid = 1'b0;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (wb_valid) n++;
        end
        chk("abort_no_wb", 64'(n), 64'd0);
        chk("abort_idle_busy", {63'd0, busy}, 64'd0);
        chk("abort_st_ready", {63'd0, st_ready}, 64'd1);
        $display("reset abort done wb_cycles=%0d", n);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
